// File: rtl/piso_transmitter_negclk_if.sv
// Parallel load / serial output bundle for piso_transmitter_negclk.
// master drives the load strobe, shift enable and word; slave is the transmitter.
interface piso_transmitter_negclk_if #(
  parameter int WIDTH = 8
);
  logic             Loadbar;
  logic             Shiftbar;
  logic [WIDTH-1:0] in;
  logic             out;
  logic             busy;
  logic             done;

  modport master (
    output Loadbar,
    output Shiftbar,
    output in,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  Loadbar,
    input  Shiftbar,
    input  in,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_transmitter_negclk.sv
// Falling-edge parallel-in/serial-out transmitter, LSB first, with active-low stall.
// Optional even-parity trailer bit when PISO_TRANSMITTER_PARITY_EN is defined.
module piso_transmitter_negclk #(
  parameter int WIDTH = 8
) (
  input  logic                      ClkN,
  input  logic                      Resetbar,
  piso_transmitter_negclk_if.slave  bus
);

`ifdef PISO_TRANSMITTER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             out_q;
  logic             busy_q;
  logic             done_q;

  // Parity (when enabled) is frozen at load time so later changes on in cannot alter it.
  function automatic logic [FRAME-1:0] frame_word(input logic [WIDTH-1:0] d);
`ifdef PISO_TRANSMITTER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_ff @(negedge ClkN or negedge Resetbar) begin
    if (!Resetbar) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (!bus.Loadbar) begin
            shreg  <= frame_word(bus.in);
            out_q  <= bus.in[0];
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            out_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          // Loadbar is deliberately ignored here: a frame in flight is never disturbed.
          if (!bus.Shiftbar) begin
            if (cnt == LAST) begin
              state  <= IDLE;
              out_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              shreg <= shreg >> 1;
              out_q <= shreg[1];
            end
          end
        end
        default: begin
          state  <= IDLE;
          out_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_piso_transmitter_negclk.sv
// Table-driven bench for piso_transmitter_negclk: vectors feed a scoreboard queue of {out,busy,done}.
// Inputs change and outputs are sampled on the rising edge, away from the active falling edge.
module tb_piso_transmitter_negclk;
  localparam int WIDTH = 8;
`ifdef PISO_TRANSMITTER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic ClkN = 1'b1;
  logic Resetbar;

  piso_transmitter_negclk_if #(.WIDTH(WIDTH)) bus ();

  piso_transmitter_negclk #(.WIDTH(WIDTH)) dut (
    .ClkN     (ClkN),
    .Resetbar (Resetbar),
    .bus      (bus)
  );

  always #5 ClkN = ~ClkN;

  typedef struct {
    string            name;
    logic             loadbar;
    logic             shiftbar;
    logic [WIDTH-1:0] din;
    logic [2:0]       exp;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic void add(string n, logic lb, logic sb, logic [WIDTH-1:0] d,
                              logic o, logic b, logic dn);
    vec_t v;
    v.name     = n;
    v.loadbar  = lb;
    v.shiftbar = sb;
    v.din      = d;
    v.exp      = {o, b, dn};
    vecs.push_back(v);
  endfunction

  // Load edge plus every following bit; par is the expected parity trailer (used only when enabled).
  // Non-load cycles present ~d on in to show the captured word is not re-sampled.
  function automatic void add_frame(string n, logic [WIDTH-1:0] d, logic par,
                                    int stall_at, int stall_len, logic stall_load);
    logic [FRAME-1:0] bits;
    bits = '0;
    bits[WIDTH-1:0] = d;
`ifdef PISO_TRANSMITTER_PARITY_EN
    bits[FRAME-1] = par;
`endif
    add({n, "_load"}, 1'b0, 1'b1, d, bits[0], 1'b1, 1'b0);
    for (int i = 1; i < FRAME; i++) begin
      if (i - 1 == stall_at)
        for (int k = 0; k < stall_len; k++)
          add({n, "_stall"}, stall_load ? 1'b0 : 1'b1, 1'b1, ~d, bits[i-1], 1'b1, 1'b0);
      add({n, "_bit"}, 1'b1, 1'b0, ~d, bits[i], 1'b1, 1'b0);
    end
  endfunction

  function automatic void add_done(string n);
    add({n, "_done"}, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic void add_idle(string n, logic sb);
    add({n, "_idle"}, 1'b1, sb, '0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check_out(string n);
    logic [2:0] got;
    logic [2:0] e;
    got = {bus.out, bus.busy, bus.done};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, got out/busy/done=%b", n, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s out/busy/done got=%b expected=%b", n, got, e);
      end
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      bus.Loadbar  = vecs[i].loadbar;
      bus.Shiftbar = vecs[i].shiftbar;
      bus.in       = vecs[i].din;
      exp_q.push_back(vecs[i].exp);
      @(negedge ClkN);
      @(posedge ClkN);
      check_out(vecs[i].name);
    end
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Main table: idle, basic frame, stalls, ignored load, back-to-back, parity-sensitive word.
    for (int i = 0; i < 3; i++) add_idle("idle", 1'b1);
    add_frame("a5", 8'hA5, 1'b0, -1, 0, 1'b0);
    add_done("a5");
    add_idle("a5", 1'b0);
    add_frame("0f", 8'h0F, 1'b0, 1, 3, 1'b0);
    add_done("0f");
    add_idle("0f", 1'b1);
    add_frame("0f_ld", 8'h0F, 1'b0, 1, 3, 1'b1);
    add_done("0f_ld");
    add_idle("0f_ld", 1'b0);
    add_frame("b2b_81", 8'h81, 1'b0, -1, 0, 1'b0);
    add_done("b2b_81");
    add_frame("b2b_7e", 8'h7E, 1'b0, -1, 0, 1'b0);
    add_done("b2b_7e");
    add_idle("b2b_7e", 1'b0);
    add_frame("07", 8'h07, 1'b1, -1, 0, 1'b0);
    add_done("07");
    add_idle("07", 1'b1);

    Resetbar     = 1'b0;
    bus.Loadbar  = 1'b1;
    bus.Shiftbar = 1'b1;
    bus.in       = '0;
    #1;
    exp_q.push_back(3'b000);
    check_out("reset_t0");
    for (int i = 0; i < 2; i++) begin
      @(negedge ClkN);
      @(posedge ClkN);
      exp_q.push_back(3'b000);
      check_out("reset_hold");
    end
    Resetbar = 1'b1;

    run_vecs();

    // Reset during a frame: outputs must clear without waiting for a clock edge.
    add_frame("ff", 8'hFF, 1'b0, -1, 0, 1'b0);
    while (vecs.size() > 4) void'(vecs.pop_back());
    run_vecs();
    bus.Loadbar  = 1'b0;
    bus.Shiftbar = 1'b0;
    bus.in       = 8'h55;
    Resetbar     = 1'b0;
    #1;
    exp_q.push_back(3'b000);
    check_out("async_reset");
    @(negedge ClkN);
    @(posedge ClkN);
    exp_q.push_back(3'b000);
    check_out("reset_mid_hold");
    Resetbar = 1'b1;

    add_idle("post_rst", 1'b0);
    add_idle("post_rst", 1'b0);
    add_frame("01", 8'h01, 1'b1, -1, 0, 1'b0);
    add_done("01");
    add_idle("01", 1'b1);
    run_vecs();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_transmitter_negclk.md
Name: piso_transmitter_negclk

Overview:
- Parallel-in, serial-out transmitter. Takes a WIDTH-bit word on an active-low load strobe and drives it out one bit per falling clock edge, LSB first.
- Serial output can be stalled with an active-low shift enable.
- Companion to the negative-edge, active-low-enable storage registers: it produces the serial bit stream those registers capture.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).

Ports:
- ClkN  input  1  clock; all state updates on the falling edge
- Resetbar  input  1  reset; asynchronous, active-low
- Loadbar  input  1  active-low load request; sampled on the falling edge of ClkN
- Shiftbar  input  1  active-low shift enable; 1 = hold the current bit
- in  input  WIDTH  parallel data word
- out  output  1  serial data bit
- busy  output  1  high while a frame is being shifted
- done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Interface (already decided): one clock, ClkN; reset is asynchronous and active-low, on Resetbar.
- All outputs are registered and update only on the falling edge of ClkN, except reset.
- Reset (Resetbar=0, takes effect immediately):
  - state=IDLE; shift register=0; bit counter=0.
  - out=0, busy=0, done=0.
- Reset mid-frame aborts the frame. No done pulse is produced.
- The first active falling edge after Resetbar rises behaves as in IDLE.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0 and out=0.
  - Falling edge with Loadbar=0: capture in into the shift register, drive out=in[0], counter=0, busy=1, state becomes SHIFT. Latency from load edge to first bit is 0 edges.
  - Falling edge with Loadbar=1: stay in IDLE.
- SHIFT, Shiftbar=1 at a falling edge: hold out, counter and shift register unchanged.
- SHIFT, Shiftbar=0 at a falling edge, counter<FRAME-1:
  - counter increments.
  - Shift register shifts right, filling with 0.
  - out = next bit.
- SHIFT, Shiftbar=0 at a falling edge, counter=FRAME-1 (last bit has been held for its cycle):
  - state becomes IDLE; out=0, busy=0.
  - done=1 for exactly one ClkN cycle.
- FRAME = WIDTH, or WIDTH+1 when the optional feature is enabled.
- Each bit is valid on out for at least one full ClkN cycle (falling edge to falling edge), longer if stalled.
- Loadbar=0 while in SHIFT is ignored. The frame in progress is not disturbed and no request is queued.
- Load on the edge where done=1 is accepted normally:
  - done clears on that edge.
  - out=new in[0] and busy=1 on that same edge.
- Back-to-back frames are therefore separated by exactly one idle cycle (the done cycle).
- Changes on in after the load edge have no effect on the frame in progress.
- Bit counter width is the smallest width that holds FRAME-1. Counting never wraps within a frame; the counter resets to 0 on every load.

Optional Feature:
- Macro: PISO_TRANSMITTER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH bits captured at load) is appended after bit WIDTH-1, so FRAME=WIDTH+1.
  - The parity bit is computed and stored at the load edge.
  - The parity bit obeys Shiftbar stalls like any data bit.
  - done pulses after the parity bit's cycle.
- Undefined:
  - No parity bit; FRAME=WIDTH; no parity logic is synthesized.

Test Plan:
1. Reset/idle: Resetbar=0 for 2 cycles, then 1 with Loadbar=1 for 3 cycles -> out=0, busy=0, done=0 throughout.
2. Basic frame (WIDTH=8, no parity): in=8'hA5, Loadbar=0 for one edge, Shiftbar=0 ->
   - out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
   - busy=1 for those 8 cycles;
   - then out=0, busy=0, done=1 for one cycle.
3. Stall: in=8'h0F, Shiftbar=1 for 3 edges after the 2nd bit -> out holds 1 for 4 cycles and the frame completes 3 cycles later. Repeat with a load request during the stall -> the request is ignored.
4. Back-to-back: load in=8'h81, then Loadbar=0 again on the done edge with in=8'h7E ->
   - second frame starts on that edge with out=0 (bit 0 of 8'h7E);
   - done is 0 after that edge;
   - serial stream is 1,0,0,0,0,0,0,1 | 0,1,1,1,1,1,1,0.
5. Reset mid-frame: Resetbar=0 after the 4th bit of 8'hFF -> out=0 and busy=0 immediately without waiting for an edge, and no done pulse. A new load of 8'h01 afterwards produces a clean frame 1,0,0,0,0,0,0,0.
6. With PISO_TRANSMITTER_PARITY_EN:
   - in=8'hA5 -> 9 bits 1,0,1,0,0,1,0,1,0, then done.
   - in=8'h07 -> 9th bit = 1.
